// File: rtl/sorted_muon_serializer.sv
// Sorted-frame serializer: ping-pong buffers the top NOUT muons of each frame
// and streams them one per cycle with first/last markers.
package muon_pkg;
    typedef struct packed {
        logic [8:0] pt;
        logic [8:0] eta;
        logic [9:0] phi;
        logic [3:0] qual;
    } muon_t;
endpackage

module sorted_muon_serializer
    import muon_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NOUT  = 8,
    parameter int CNT_W = 16,
    localparam int IDX_W = (NOUT > 1) ? $clog2(NOUT) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  muon_t [0:WIDTH-1]      m,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output muon_t                  out_muon,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   out_first,
    output logic                   out_last,
    output logic [CNT_W-1:0]       drop_cnt
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOUT - 1);

    logic [0:0]       r_state;
    logic [1:0]       r_full;
    logic             r_wr;
    logic             r_rd;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_drop;
    muon_t            r_buf [2][NOUT];

    logic       w_send;
    logic       w_hs;
    logic       w_last;
    logic       w_free;
    logic       w_cap;
    logic       w_drop;
    logic [1:0] w_full_nxt;
    logic       w_rd_nxt;

    assign w_send = (r_state == S_SEND);
    assign w_hs   = w_send & out_ready;
    assign w_last = (r_idx == LAST_IDX);
    assign w_free = w_hs & w_last;

    // A buffer drained at this edge can take the incoming frame at the same edge.
    assign in_ready = ~(&r_full) | w_free;
    assign w_cap    = in_valid & in_ready;
    assign w_drop   = in_valid & ~in_ready;

    always_comb begin
        w_full_nxt = r_full;
        if (w_free) w_full_nxt[r_rd] = 1'b0;
        if (w_cap)  w_full_nxt[r_wr] = 1'b1;
        w_rd_nxt = r_rd ^ w_free;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_full  <= 2'b00;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_idx   <= '0;
            r_drop  <= '0;
        end else begin
            // Stay in SEND across frames whenever the next read buffer is loaded.
            r_state <= w_full_nxt[w_rd_nxt] ? S_SEND : S_IDLE;
            r_full  <= w_full_nxt;
            r_rd    <= w_rd_nxt;
            if (w_cap) r_wr <= ~r_wr;
            if (w_hs)  r_idx <= w_last ? '0 : r_idx + 1'b1;
            if (w_drop && (r_drop != '1)) r_drop <= r_drop + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_cap) begin
            for (int i = 0; i < NOUT; i++) begin
                r_buf[r_wr][i] <= m[i];
            end
        end
    end

    assign out_valid = w_send;
    assign out_muon  = w_send ? r_buf[r_rd][r_idx] : '0;
    assign out_idx   = r_idx;
    assign out_first = w_send & (r_idx == '0);
    assign out_last  = w_send & w_last;
    assign drop_cnt  = r_drop;

endmodule
